// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg: mode constants and level-width helper shared by the tx_fifo family.
package tx_fifo_pkg;
  localparam int TX_FIFO_MODE_STD  = 0;
  localparam int TX_FIFO_MODE_FWFT = 1;
  function automatic int tx_fifo_lvl_width(input int addr_width);
    return addr_width + 1;
  endfunction
endpackage

// File: rtl/tx_fifo_sc_mem.sv
// tx_fifo_sc_mem: register array with one write port and an asynchronous read port.
module tx_fifo_sc_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;
  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/tx_fifo_sc.sv
// tx_fifo_sc: single-clock transmit FIFO with margins, level, flush and optional FWFT read.
// Define TX_FIFO_SC_ERR_EN to add sticky overflow/underflow flags o_ovf/o_udf.
module tx_fifo_sc
  import tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_MARGIN  = 4,
  parameter int AEMPTY_MARGIN = 4,
  parameter int FWFT          = TX_FIFO_MODE_STD
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_flush,
  input  logic                                     i_push,
  input  logic [DATA_WIDTH-1:0]                    i_wdata,
  input  logic                                     i_pop,
  output logic [DATA_WIDTH-1:0]                    o_rdata,
  output logic                                     o_rvalid,
  output logic                                     o_full,
  output logic                                     o_empty,
  output logic                                     o_afull,
  output logic                                     o_aempty,
  output logic [tx_fifo_lvl_width(ADDR_WIDTH)-1:0] o_level
`ifdef TX_FIFO_SC_ERR_EN
  ,
  output logic                                     o_ovf,
  output logic                                     o_udf
`endif
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW = tx_fifo_lvl_width(ADDR_WIDTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL = LW'(DEPTH - AFULL_MARGIN);
  localparam logic [LW-1:0] AE_LVL = LW'(AEMPTY_MARGIN);
  if (AFULL_MARGIN >= DEPTH || AEMPTY_MARGIN >= DEPTH) begin : g_bad_margin
    $error("tx_fifo_sc: margins must be smaller than DEPTH");
  end
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic push_acc, pop_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // a pop frees the slot a same-cycle push needs, so full does not block it
  assign pop_acc  = i_pop & (level != '0);
  assign push_acc = i_push & ((level != FULL_LVL) | pop_acc);
  assign o_level  = level;
  assign o_full   = level == FULL_LVL;
  assign o_empty  = level == '0;
  assign o_afull  = level >= AF_LVL;
  assign o_aempty = level <= AE_LVL;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (i_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      wptr  <= wptr + ADDR_WIDTH'(push_acc);
      rptr  <= rptr + ADDR_WIDTH'(pop_acc);
      level <= level + LW'(push_acc) - LW'(pop_acc);
    end
  tx_fifo_sc_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .i_clk   (i_clk),
    .i_we    (push_acc & ~i_flush),
    .i_waddr (wptr),
    .i_wdata (i_wdata),
    .i_raddr (rptr),
    .o_rdata (mem_rdata)
  );
  if (FWFT == TX_FIFO_MODE_FWFT) begin : g_fwft
    assign o_rdata  = mem_rdata;
    assign o_rvalid = ~o_empty;
  end else begin : g_std
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        o_rdata  <= '0;
        o_rvalid <= 1'b0;
      end else if (i_flush) begin
        o_rvalid <= 1'b0;
      end else begin
        o_rvalid <= pop_acc;
        if (pop_acc) o_rdata <= mem_rdata;
      end
  end
`ifdef TX_FIFO_SC_ERR_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else if (i_flush) begin
      o_ovf <= 1'b0;
      o_udf <= 1'b0;
    end else begin
      o_ovf <= o_ovf | (i_push & ~push_acc);
      o_udf <= o_udf | (i_pop & ~pop_acc);
    end
`else
  // without error reporting, rejected pushes and pops leave no trace
`endif
endmodule
